// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: scanning reader for a 4x4 matrix keypad.
// Drives one column at a time and samples the row lines through a 2-flop
// synchronizer. A full scan is debounced and then reported as a 5-bit key code.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   key_row[3:0] row sense lines, active high, asynchronous to clk
//   key_col[3:0] one-hot column drive (4'b1000 = col 0 ... 4'b0001 = col 3)
//   key_code[4:0] accepted key {1'b0, row, col}; held after release
//   key_valid    one-clk pulse on an accepted press (or an auto-repeat)
//   key_pressed  level, high from acceptance until the release is accepted
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat pulses every
// REPEAT_SCANS full scans while a key is held.

module keypad_scan_4x4 #(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned DEB_SCANS    = 4,
  parameter int unsigned REPEAT_SCANS = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = $clog2(DEB_SCANS + 1);

  // Elaboration-time parameter range checks
  if (CLK_DIV < 4) begin : g_chk_div
    $error("keypad_scan_4x4: CLK_DIV must be >= 4");
  end
  if (DEB_SCANS < 2) begin : g_chk_deb
    $error("keypad_scan_4x4: DEB_SCANS must be >= 2");
  end
  if (REPEAT_SCANS < 1) begin : g_chk_rep
    $error("keypad_scan_4x4: REPEAT_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic [1:0]       col_idx_c;
  logic             row_any_c;
  logic [1:0]       row_idx_c;
  logic             acc_hit;
  logic [3:0]       acc_code;
  logic             prev_hit_c;
  logic             scan_hit_c;
  logic [3:0]       scan_code_c;
  logic             scan_end_c;

  state_t           state, state_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc_c;
  logic [4:0]       code_nxt;
  logic             valid_nxt;
  logic             pressed_nxt;
  logic             same_key_c;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_cnt, rep_nxt, rep_inc_c;
`endif

  // Scan tick and column decode
  assign tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_comb begin
    col_idx_c = 2'd3;
    case (key_col)
      4'b1000: col_idx_c = 2'd0;
      4'b0100: col_idx_c = 2'd1;
      4'b0010: col_idx_c = 2'd2;
      default: col_idx_c = 2'd3;
    endcase
  end

  // Lowest-index row wins within a column
  always_comb begin
    row_any_c = |row_sync;
    row_idx_c = 2'd3;
    if (row_sync[0])      row_idx_c = 2'd0;
    else if (row_sync[1]) row_idx_c = 2'd1;
    else if (row_sync[2]) row_idx_c = 2'd2;
    else                  row_idx_c = 2'd3;
  end

  // Per-scan accumulation: first hit in column order is kept; col 0 starts fresh
  always_comb begin
    prev_hit_c  = (col_idx_c == 2'd0) ? 1'b0 : acc_hit;
    scan_hit_c  = prev_hit_c | row_any_c;
    scan_code_c = prev_hit_c ? acc_code : {row_idx_c, col_idx_c};
    scan_end_c  = tick_c && (col_idx_c == 2'd3);
  end

  // Next-state and registered-output logic, evaluated once per scan end
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    code_nxt    = key_code;
    valid_nxt   = 1'b0;
    pressed_nxt = key_pressed;
    cnt_inc_c   = cnt + CNT_W'(1);
    same_key_c  = scan_hit_c && (scan_code_c == key_code[3:0]);
`ifdef KEY_REPEAT_EN
    rep_nxt     = rep_cnt;
    rep_inc_c   = rep_cnt + REP_W'(1);
`endif
    if (scan_end_c) begin
      case (state)
        IDLE: begin
          if (scan_hit_c) begin
            state_nxt = DEBOUNCE;
            cand_nxt  = scan_code_c;
            cnt_nxt   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!scan_hit_c) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (scan_code_c != cand) begin
            cand_nxt = scan_code_c;
            cnt_nxt  = CNT_W'(1);
          end else if (cnt_inc_c == CNT_W'(DEB_SCANS)) begin
            state_nxt   = PRESSED;
            code_nxt    = {1'b0, cand};
            pressed_nxt = 1'b1;
            valid_nxt   = 1'b1;
            cnt_nxt     = '0;
`ifdef KEY_REPEAT_EN
            rep_nxt     = '0;
`endif
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end
        PRESSED: begin
          if (same_key_c) begin
`ifdef KEY_REPEAT_EN
            if (rep_inc_c == REP_W'(REPEAT_SCANS)) begin
              valid_nxt = 1'b1;
              rep_nxt   = '0;
            end else begin
              rep_nxt = rep_inc_c;
            end
`endif
          end else begin
            state_nxt = RELEASE;
            cnt_nxt   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (same_key_c) begin
            // Release bounce: back to held without a new pulse
            state_nxt = PRESSED;
            cnt_nxt   = '0;
`ifdef KEY_REPEAT_EN
            rep_nxt   = '0;
`endif
          end else if (cnt_inc_c == CNT_W'(DEB_SCANS)) begin
            state_nxt   = IDLE;
            pressed_nxt = 1'b0;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta    <= '0;
      row_sync    <= '0;
      div_cnt     <= '0;
      key_col     <= 4'b1000;
      acc_hit     <= 1'b0;
      acc_code    <= '0;
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
      div_cnt  <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) begin
        key_col  <= {key_col[0], key_col[3:1]};
        acc_hit  <= scan_hit_c;
        acc_code <= scan_code_c;
      end
      state       <= state_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      key_code    <= code_nxt;
      key_valid   <= valid_nxt;
      key_pressed <= pressed_nxt;
`ifdef KEY_REPEAT_EN
      rep_cnt     <= rep_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4: directed bench for keypad_scan_4x4 with a behavioural
// keypad matrix (keys[r*4+c] connects row r to column c).
// CLK_DIV=4, DEB_SCANS=4, REPEAT_SCANS=6 -> one full scan is 16 clk.

module tb_keypad_scan_4x4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int pulses;
  int scan_idx;
  int pulse_at [8];

  always #5 clk = ~clk;

  // Keypad matrix: a closed key connects its row to its driven column
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && key_col[3-c]) key_row[r] = 1'b1;
  end

  keypad_scan_4x4 #(
    .CLK_DIV     (4),
    .DEB_SCANS   (4),
    .REPEAT_SCANS(6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; logs key_valid pulses
  task automatic step();
    @(posedge clk);
    #1;
    if (key_valid) begin
      if (pulses < 8) pulse_at[pulses] = scan_idx;
      pulses++;
    end
  endtask

  task automatic run_scans(input int n);
    repeat (n) begin
      scan_idx++;
      repeat (16) step();
    end
  endtask

  task automatic clear_log();
    pulses   = 0;
    scan_idx = 0;
    for (int i = 0; i < 8; i++) pulse_at[i] = -1;
  endtask

  initial begin
    keys  = '0;
    reset = 1'b0;
    clear_log();

    // 1: reset values and column rotation
    repeat (3) step();
    check("rst_col", key_col, 4'b1000);
    check("rst_code", key_code, 5'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_pressed", key_pressed, 1'b0);
    reset = 1'b1;
    repeat (3) step();
    check("col0_hold", key_col, 4'b1000);
    step();
    check("col1", key_col, 4'b0100);
    repeat (4) step();
    check("col2", key_col, 4'b0010);
    repeat (4) step();
    check("col3", key_col, 4'b0001);
    repeat (4) step();
    check("col_wrap", key_col, 4'b1000);

    // 2: key 6 (row 1, col 2) held 8 scans
    clear_log();
    keys = 16'h0040;
    run_scans(3);
    check("k6_no_early_pulse", pulses, 0);
    check("k6_not_pressed_yet", key_pressed, 1'b0);
    run_scans(1);
    check("k6_pulse_cnt", pulses, 1);
    check("k6_pulse_scan", pulse_at[0], 4);
    check("k6_code", key_code, 5'd6);
    check("k6_pressed", key_pressed, 1'b1);
    run_scans(4);
    check("k6_single_pulse", pulses, 1);
    keys = '0;
    run_scans(3);
    check("k6_rel_pending", key_pressed, 1'b1);
    run_scans(1);
    check("k6_released", key_pressed, 1'b0);
    check("k6_code_held", key_code, 5'd6);

    // 3: bouncing key 6 on alternate scans
    clear_log();
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      run_scans(1);
    end
    check("bounce_no_pulse", pulses, 0);
    check("bounce_not_pressed", key_pressed, 1'b0);

    // 4: keys 0 and 15 together, priority to col 0 / row 0
    clear_log();
    keys = 16'h8001;
    run_scans(5);
    check("multi_pulse_cnt", pulses, 1);
    check("multi_pulse_scan", pulse_at[0], 4);
    check("multi_code", key_code, 5'd0);
    check("multi_pressed", key_pressed, 1'b1);
    keys = '0;
    run_scans(3);
    check("multi_rel_pending", key_pressed, 1'b1);
    run_scans(1);
    check("multi_released", key_pressed, 1'b0);
    check("multi_code_held", key_code, 5'd0);

    // 5: reset during debounce of key 9 discards partial state
    clear_log();
    keys = 16'h0200;
    run_scans(3);
    check("k9_pre_reset_no_pulse", pulses, 0);
    reset = 1'b0;
    repeat (3) step();
    check("k9_rst_col", key_col, 4'b1000);
    check("k9_rst_pressed", key_pressed, 1'b0);
    reset = 1'b1;
    scan_idx = 0;
    run_scans(3);
    check("k9_after_reset_no_pulse", pulses, 0);
    check("k9_after_reset_not_pressed", key_pressed, 1'b0);
    run_scans(1);
    check("k9_redebounce_pulse", pulses, 1);
    check("k9_code", key_code, 5'd9);
    keys = '0;
    run_scans(4);
    check("k9_released", key_pressed, 1'b0);

    // 6: key 15 held 20 scans (auto-repeat depends on build)
    clear_log();
    keys = 16'h8000;
    run_scans(20);
    check("k15_code", key_code, 5'd15);
    check("k15_first_pulse", pulse_at[0], 4);
`ifdef KEY_REPEAT_EN
    check("k15_pulse_cnt", pulses, 3);
    check("k15_second_pulse", pulse_at[1], 10);
    check("k15_third_pulse", pulse_at[2], 16);
`else
    check("k15_pulse_cnt", pulses, 1);
`endif

    // Switching to key 5 while 15 is held: release must be accepted first
    clear_log();
    keys = 16'h0020;
    run_scans(7);
    check("k5_no_pulse_during_switch", pulses, 0);
    check("k5_not_pressed_yet", key_pressed, 1'b0);
    run_scans(1);
    check("k5_pulse_cnt", pulses, 1);
    check("k5_pulse_scan", pulse_at[0], 8);
    check("k5_code", key_code, 5'd5);
    check("k5_pressed", key_pressed, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
